// File: rtl/ex_alu_stage_if.sv
// Handshake and payload bundle for the execute-stage ALU: upstream op channel plus downstream result channel.
// The overflow signal exists only when ALU_OVERFLOW_EN is defined.
interface ex_alu_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [4:0]       rd_out;
`ifdef ALU_OVERFLOW_EN
  logic             overflow;

  modport slave (
    input  in_valid, alu_ctr, op_a, op_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out, overflow
  );
  modport master (
    output in_valid, alu_ctr, op_a, op_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, overflow
  );
`else
  modport slave (
    input  in_valid, alu_ctr, op_a, op_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out
  );
  modport master (
    output in_valid, alu_ctr, op_a, op_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out
  );
`endif
endinterface

// File: rtl/ex_alu_stage.sv
// Registered execute-stage ALU with a two-entry skid buffer (main + skid); in_ready comes straight from a flop.
// Optional signed-overflow output and storage enabled by defining ALU_OVERFLOW_EN.
//
// state   | meaning
// EMPTY   | main and skid both empty
// ONE     | main holds the presented entry, skid empty
// FULL    | main presented, skid holds the next entry; in_ready low
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_alu_stage_if.slave     bus
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b10;
  localparam logic [1:0] S_FULL  = 2'b11;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_BNE = 4'b1111;

`ifdef ALU_OVERFLOW_EN
  localparam int OVW = 1;
`else
  localparam int OVW = 0;
`endif
  localparam int EW = WIDTH + 6 + OVW;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [EW-1:0]    new_entry;

  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [1:0]       state;
  logic             accept;
  logic             drain;

  assign add_res = bus.op_a + bus.op_b;
  assign sub_res = bus.op_a - bus.op_b;
  assign slt_bit = $signed(bus.op_a) < $signed(bus.op_b);

  // bne reports "branch taken" on zero so branch logic treats beq (via sub) and bne alike
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b1;
    case (bus.alu_ctr)
      C_ADD: begin alu_res = add_res;               alu_zero = (add_res == '0); end
      C_SUB: begin alu_res = sub_res;               alu_zero = (sub_res == '0); end
      C_AND: begin alu_res = bus.op_a & bus.op_b;   alu_zero = ((bus.op_a & bus.op_b) == '0); end
      C_OR:  begin alu_res = bus.op_a | bus.op_b;   alu_zero = ((bus.op_a | bus.op_b) == '0); end
      C_SLT: begin alu_res = {{(WIDTH-1){1'b0}}, slt_bit}; alu_zero = !slt_bit; end
      C_BNE: begin alu_res = sub_res;               alu_zero = (bus.op_a != bus.op_b); end
      default: begin alu_res = '0;                  alu_zero = 1'b1; end
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    case (bus.alu_ctr)
      C_ADD:        alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                              (add_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      C_SUB, C_BNE: alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                              (sub_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      default:      alu_ovf = 1'b0;
    endcase
  end

  assign new_entry    = {alu_res, alu_zero, bus.rd_in, alu_ovf};
  assign bus.overflow = main_q[0];
`else
  assign new_entry = {alu_res, alu_zero, bus.rd_in};
`endif

  assign state  = {main_valid_q, skid_valid_q};
  assign accept = bus.in_valid && !skid_valid_q;
  assign drain  = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_d       = new_entry;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            main_d = new_entry;
          end else if (drain) begin
            main_valid_d = 1'b0;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = new_entry;
          end
        end
        S_FULL: begin
          if (drain) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign bus.result    = main_q[EW-1 -: WIDTH];
  assign bus.zero      = main_q[EW-1-WIDTH];
  assign bus.rd_out    = main_q[EW-2-WIDTH -: 5];

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage: ALU codes, backpressure, streaming, flush, async reset.
// Overflow checks are compiled in when ALU_OVERFLOW_EN is defined.
module tb_ex_alu_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_chk;
  int   n_pass;

  ex_alu_stage_if #(.WIDTH(32)) bus ();

  ex_alu_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.alu_ctr  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd_in    = rd;
  endtask

  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_z);
    bus.out_ready = 1'b1;
    drive(c, a, b, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_res"},   64'(bus.result),    64'(exp_res));
    chk({tag, "_zero"},  64'(bus.zero),      64'(exp_z));
    tick();
  endtask

  initial begin
    int seen;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctr   = 4'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.rd_in     = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    chk("rst_rd",        64'(bus.rd_out),    64'd0);
`ifdef ALU_OVERFLOW_EN
    chk("rst_ovf",       64'(bus.overflow),  64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // single add with latency 1
    bus.out_ready = 1'b1;
    drive(4'b0010, 32'd5, 32'd7, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_res",   64'(bus.result),    64'd12);
    chk("add_zero",  64'(bus.zero),      64'd0);
    chk("add_rd",    64'(bus.rd_out),    64'd3);
    tick();
    chk("add_drained", 64'(bus.out_valid), 64'd0);

    do_op("sub77",   4'b0110, 32'd7, 32'd7, 32'd0, 1'b1);
    do_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    do_op("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    do_op("bne_eq",  4'b1111, 32'd4, 32'd4, 32'd0, 1'b0);
    do_op("bne_ne",  4'b1111, 32'd4, 32'd5, 32'hFFFF_FFFF, 1'b1);
    do_op("bad1010", 4'b1010, 32'd3, 32'd4, 32'd0, 1'b1);
    do_op("and",     4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    do_op("or",      4'b0001, 32'd6, 32'd9, 32'd15, 1'b0);
    do_op("addwrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

    // backpressure: fill main then skid, then drain in order
    bus.out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd1);
    tick();
    chk("bp1_in_ready", 64'(bus.in_ready),  64'd1);
    chk("bp1_res",      64'(bus.result),    64'd2);
    drive(4'b0001, 32'd6, 32'd9, 5'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("bp2_in_ready", 64'(bus.in_ready),  64'd0);
    chk("bp2_valid",    64'(bus.out_valid), 64'd1);
    chk("bp2_res",      64'(bus.result),    64'd2);
    tick();
    chk("bp_hold_res",  64'(bus.result),    64'd2);
    chk("bp_hold_rd",   64'(bus.rd_out),    64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_second_res",   64'(bus.result),    64'd15);
    chk("bp_second_rd",    64'(bus.rd_out),    64'd2);
    chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // streaming, no bubbles
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0010, 32'(i), 32'(i), 5'(i));
      tick();
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_res",   64'(bus.result),    64'(2 * i));
      chk("stream_rd",    64'(bus.rd_out),    64'(i));
      chk("stream_rdy",   64'(bus.in_ready),  64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_end", 64'(bus.out_valid), 64'd0);

    // flush in FULL with an input presented
    bus.out_ready = 1'b0;
    drive(4'b0010, 32'd10, 32'd10, 5'd5);
    tick();
    drive(4'b0010, 32'd20, 32'd20, 5'd6);
    tick();
    chk("fl_full_rdy", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(4'b0010, 32'd30, 32'd30, 5'd7);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_rdy",   64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("fl_nothing_after", 64'(seen), 64'd0);

    // flush in ONE with in_ready high: input must not be accepted
    bus.out_ready = 1'b0;
    drive(4'b0010, 32'd2, 32'd2, 5'd4);
    tick();
    flush = 1'b1;
    drive(4'b0010, 32'd3, 32'd3, 5'd8);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("fl1_still_empty", 64'(bus.out_valid), 64'd0);

`ifdef ALU_OVERFLOW_EN
    do_op("ovf_add", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
    bus.out_ready = 1'b1;
    drive(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd1);
    tick();
    chk("ovf_add_bit", 64'(bus.overflow), 64'd1);
    drive(4'b0110, 32'h8000_0000, 32'd1, 5'd1);
    tick();
    chk("ovf_sub_bit", 64'(bus.overflow), 64'd1);
    chk("ovf_sub_res", 64'(bus.result),   64'h7FFF_FFFF);
    drive(4'b0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd1);
    tick();
    chk("ovf_and_bit", 64'(bus.overflow), 64'd0);
    drive(4'b0010, 32'd1, 32'd1, 5'd1);
    tick();
    chk("ovf_add_none", 64'(bus.overflow), 64'd0);
    bus.in_valid = 1'b0;
    tick();
`endif

    // async reset mid-operation, no clock edge
    bus.out_ready = 1'b0;
    drive(4'b0010, 32'd8, 32'd8, 5'd2);
    tick();
    drive(4'b0010, 32'd9, 32'd9, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",  64'(bus.out_valid), 64'd0);
    chk("ar_rdy",    64'(bus.in_ready),  64'd1);
    chk("ar_result", 64'(bus.result),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_after", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Registered execute-stage ALU that sits directly downstream of the ALU-control decoder. It consumes the 4-bit ALU control code plus two operands and the destination register tag. It computes the result and the branch/zero flag, and presents them on a registered valid/ready output. A two-entry skid buffer decouples the upstream decode stage from downstream stalls without combinational ready paths.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush; drops all buffered entries
- in_valid  input  1  upstream holds a valid operation
- in_ready  output  1  stage can accept; registered, depends only on internal state
- alu_ctr  input  4  control code: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1111 bne
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- rd_in  input  5  destination register tag, passed through
- out_valid  output  1  result entry valid
- out_ready  input  1  downstream accepts the entry
- result  output  WIDTH  ALU result
- zero  output  1  flag (see Operation)
- rd_out  output  5  tag of the presented entry
- overflow  output  1  signed overflow; present only with ALU_OVERFLOW_EN

## Operation
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- The result is computed combinationally from the input and captured at transfer. Stored entry: {result, zero, rd, overflow}.
- add: a+b mod 2^WIDTH.
- sub: a−b mod 2^WIDTH.
- and: a&b.
- or: a|b.
- slt: result = 1 if $signed(a) < $signed(b), else 0. Uses a true signed compare, not the sub sign bit.
- bne: result = a−b.
- zero = (result == 0) for every code except bne. For bne, zero = (a != b), so downstream branch logic reads zero as "take branch" for both beq (via sub) and bne.
- Any other code: result = 0, zero = 1, overflow = 0.
- Buffer: a main (output) register and a skid register.
  - in_ready = !skid_valid.
  - If the main register is empty or being drained, an accepted entry goes to main.
  - Otherwise an accepted entry goes to skid.
  - When main drains and skid is valid, skid moves to main.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- States are implied by {main_valid, skid_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1). The combination (0,1) is illegal and never reached.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without drain.
  - ONE→EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - FULL→ONE on drain. No accept is possible in FULL because in_ready = 0.

## Timing
- Latency: an entry accepted in cycle N is visible on the outputs in cycle N+1 when the stage was EMPTY, or when it was ONE and draining.
- Throughput: 1 entry/cycle while out_ready = 1.
- Reset (async, rst_n = 0): out_valid = 0, skid empty, in_ready = 1, result = 0, zero = 0, rd_out = 0, overflow = 0. Data registers also reset.
- out_valid and the payload stay stable while out_valid && !out_ready.
- flush: at the next edge main and skid become invalid and in_ready = 1. Any input presented in the flush cycle is discarded. flush takes priority over accept and drain in the same cycle.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Configuration
- ALU_OVERFLOW_EN defined: the overflow port exists.
  - add: asserted when the operand signs are equal and the result sign differs.
  - sub and bne: asserted when the operand signs differ and the result sign differs from a.
  - Deasserted for all other codes.
  - The bit is stored in both buffer entries.
- ALU_OVERFLOW_EN undefined: the port and its storage are absent. All other behaviour is identical.

## Test plan
- Reset then single op: add, a=5, b=7, rd=3, out_ready=1 → next cycle out_valid=1, result=12, zero=0, rd_out=3.
- Codes with WIDTH=32:
  - sub 7−7 → result 0, zero 1.
  - slt a=0xFFFFFFFF, b=1 → result 1.
  - bne a=4, b=4 → zero 0.
  - bne a=4, b=5 → zero 1.
  - code 1010 → result 0, zero 1.
- Backpressure: out_ready=0, push 2 ops (add 1+1, or 6|9). Expect in_ready=0 after the second accept. Raise out_ready → results 2 then 15 in order, in_ready returns to 1.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with add i+i → 8 consecutive results 0,2,…,14 with no bubbles.
- Flush in the FULL state while in_valid=1 → next cycle out_valid=0, in_ready=1, and neither the buffered entries nor the input entry ever appear.
- ALU_OVERFLOW_EN: add 0x7FFFFFFF+1 → overflow=1, result 0x80000000. sub 0x80000000−1 → overflow=1. and → overflow=0. Async rst_n pulse mid-stream clears out_valid without a clock edge.
